// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART transmit controller: FSM states, requester count,
// default frame length and a byte-lane extraction helper.
package uart_ctrl_pkg;

    localparam int NREQ          = 4;
    localparam int FRAME_LEN_DEF = 20;

    typedef enum logic [2:0] {
        FLUSH = 3'd0,
        IDLE  = 3'd1,
        START = 3'd2,
        FRAME = 3'd3,
        GAP   = 3'd4
    } state_t;

    // Requester i owns byte lane [8i+7:8i] of the packed data bus.
    function automatic logic [7:0] byte_lane(input logic [31:0] data, input logic [1:0] idx);
        return data[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle of the UART transmit arbiter.
// The master side drives requests and bytes; the slave side is the arbiter.
interface uart_tx_arbiter_if;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  ack;
    logic        tx_ce;
    logic [7:0]  tx_data;
    logic [1:0]  gnt_id;
    logic        busy;

    modport master (output req, data, input ack, tx_ce, tx_data, gnt_id, busy);
    modport slave  (input req, data, output ack, tx_ce, tx_data, gnt_id, busy);
endinterface

// File: rtl/rr_arbiter4.sv
// Four-way round-robin winner selection starting at ptr; with prio_en set,
// requester 0 wins outright and 1..3 rotate among themselves.
module rr_arbiter4
    import uart_ctrl_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    input  logic            prio_en,
    output logic            valid,
    output logic [1:0]      index
);

    logic [NREQ-1:0] masked_s;
    logic [1:0]      cand_s;

    // Scan from farthest to nearest so the candidate closest to ptr is kept last.
    always_comb begin
        masked_s = prio_en ? (req & 4'b1110) : req;
        valid    = 1'b0;
        index    = 2'd0;
        cand_s   = 2'd0;
        if (prio_en && req[0]) begin
            valid = 1'b1;
            index = 2'd0;
        end else begin
            for (int k = 3; k >= 0; k--) begin
                cand_s = ptr + 2'(k);
                valid  = valid | masked_s[cand_s];
                index  = masked_s[cand_s] ? cand_s : index;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates four byte requesters onto one UART transmitter with a FRAME_LEN-clock frame.
// Define UART_TX_ARB_PRIO_EN to give requester 0 absolute priority.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int GAP_LEN   = 2
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.slave   bus
);

    localparam logic [4:0] FLUSH_LAST = 5'(FRAME_LEN - 1);
    localparam logic [4:0] FRAME_LAST = 5'(FRAME_LEN - 2);
    localparam logic [4:0] GAP_LAST   = 5'(GAP_LEN - 1);

`ifdef UART_TX_ARB_PRIO_EN
    localparam logic PRIO_EN = 1'b1;
`else
    localparam logic PRIO_EN = 1'b0;
`endif

    state_t      state_r, state_next_s;
    logic [4:0]  cnt_r, cnt_next_s;
    logic [1:0]  ptr_r;
    logic        tx_ce_r, tx_ce_next_s;
    logic [7:0]  tx_data_r;
    logic [1:0]  gnt_id_r;
    logic [3:0]  ack_r, ack_next_s;
    logic        busy_r;
    logic        grant_s;
    logic        win_valid_s;
    logic [1:0]  win_idx_s;

    rr_arbiter4 u_arb (
        .req     (bus.req),
        .ptr     (ptr_r),
        .prio_en (PRIO_EN),
        .valid   (win_valid_s),
        .index   (win_idx_s)
    );

    // Next-state, frame/gap counting and strobe generation.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        ack_next_s   = 4'b0000;
        tx_ce_next_s = 1'b1;
        grant_s      = 1'b0;
        case (state_r)
            FLUSH: begin
                if (cnt_r == 5'd0) begin
                    state_next_s = IDLE;
                end else begin
                    cnt_next_s = cnt_r - 5'd1;
                end
            end
            IDLE: begin
                if (win_valid_s) begin
                    state_next_s = START;
                    tx_ce_next_s = 1'b0;
                    grant_s      = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                state_next_s = FRAME;
                cnt_next_s   = FRAME_LAST;
            end
            FRAME: begin
                if (cnt_r == 5'd0) begin
                    ack_next_s = 4'b0001 << gnt_id_r;
                    if (GAP_LEN == 0) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = GAP;
                        cnt_next_s   = GAP_LAST;
                    end
                end else begin
                    cnt_next_s = cnt_r - 5'd1;
                end
            end
            GAP: begin
                if (cnt_r == 5'd0) begin
                    state_next_s = IDLE;
                end else begin
                    cnt_next_s = cnt_r - 5'd1;
                end
            end
            default: begin
                state_next_s = FLUSH;
                cnt_next_s   = FLUSH_LAST;
            end
        endcase
    end

    // State, counter and registered outputs; the grant is latched only when leaving IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= FLUSH;
            cnt_r     <= FLUSH_LAST;
            ptr_r     <= 2'd0;
            tx_ce_r   <= 1'b1;
            tx_data_r <= 8'h00;
            gnt_id_r  <= 2'd0;
            ack_r     <= 4'b0000;
            busy_r    <= 1'b1;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            tx_ce_r <= tx_ce_next_s;
            ack_r   <= ack_next_s;
            busy_r  <= (state_next_s != IDLE);
            if (grant_s) begin
                tx_data_r <= byte_lane(bus.data, win_idx_s);
                gnt_id_r  <= win_idx_s;
                ptr_r     <= win_idx_s + 2'd1;
            end else begin
                tx_data_r <= tx_data_r;
                gnt_id_r  <= gnt_id_r;
                ptr_r     <= ptr_r;
            end
        end
    end

    assign bus.tx_ce   = tx_ce_r;
    assign bus.tx_data = tx_data_r;
    assign bus.gnt_id  = gnt_id_r;
    assign bus.ack     = ack_r;
    assign bus.busy    = busy_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a vector table of single grants plus
// hand-written sequences for reset, all-request rotation, mid-frame drop/reset and zero gap.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_arbiter_if bus ();
    uart_tx_arbiter_if bus2 ();

    uart_tx_arbiter #(.FRAME_LEN(20), .GAP_LEN(2)) dut (.clk(clk), .rst(rst), .bus(bus));
    uart_tx_arbiter #(.FRAME_LEN(20), .GAP_LEN(0)) dut0 (.clk(clk), .rst(rst), .bus(bus2));

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [7:0]  exp_byte;
        logic [1:0]  exp_gnt;
        logic [3:0]  exp_ack;
    } vec_t;

    vec_t vecs [6];

    // Serial transmitter + receiver model on the zero-gap instance: 2 clocks per bit, LSB first.
    logic       m_act;
    int         m_pos;
    logic [9:0] m_sh;
    logic [9:0] m_rx [4];
    int         m_cnt;

    function automatic logic line_at(input int p, input logic [7:0] d);
        int b;
        b = p / 2;
        if (b == 0) return 1'b0;
        else if (b == 9) return 1'b1;
        else return d[b-1];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_act <= 1'b0;
            m_pos <= 0;
            m_cnt <= 0;
        end else if (!m_act) begin
            if (bus2.tx_ce == 1'b0) begin
                m_act <= 1'b1;
                m_pos <= 1;
            end
        end else begin
            if (m_pos % 2 == 1) m_sh <= {line_at(m_pos, bus2.tx_data), m_sh[9:1]};
            if (m_pos == 19) begin
                m_act <= 1'b0;
                if (m_cnt < 4) m_rx[m_cnt] <= {line_at(m_pos, bus2.tx_data), m_sh[9:1]};
                m_cnt <= m_cnt + 1;
            end
            m_pos <= m_pos + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reset for one edge, check reset values, then measure the flush length.
    task automatic reset_and_flush();
        int   n;
        logic ack_seen;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_tx_ce", 32'(bus.tx_ce), 32'd1);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_gnt_id", 32'(bus.gnt_id), 32'd0);
        n = 0;
        ack_seen = 1'b0;
        while (bus.busy === 1'b1 && n < 100) begin
            if (bus.ack != 4'b0000 || bus.tx_ce != 1'b1) ack_seen = 1'b1;
            @(negedge clk);
            n++;
        end
        check("flush_len", 32'(n), 32'd20);
        check("flush_quiet", 32'(ack_seen), 32'd0);
    endtask

    // One complete frame on the main instance: start strobe, hold, ack pulse.
    task automatic run_frame(input logic [7:0] exp_byte, input logic [1:0] exp_gnt,
                             input logic [3:0] exp_ack, input bit keep,
                             input int drop_at, input logic [3:0] drop_req, output int t0);
        int   n;
        logic hold_ok;
        n = 0;
        t0 = -1;
        while (bus.tx_ce !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check("tx_ce_timeout", 32'(n), 32'd0);
            return;
        end
        t0 = cyc;
        check("start_byte", 32'(bus.tx_data), 32'(exp_byte));
        check("start_gnt", 32'(bus.gnt_id), 32'(exp_gnt));
        hold_ok = 1'b1;
        for (int i = 1; i < 20; i++) begin
            @(negedge clk);
            if (bus.tx_data != exp_byte || bus.gnt_id != exp_gnt || bus.ack != 4'b0000 ||
                bus.tx_ce != 1'b1 || bus.busy != 1'b1) hold_ok = 1'b0;
            if (i == drop_at) bus.req = drop_req;
        end
        check("frame_hold", 32'(hold_ok), 32'd1);
        @(negedge clk);
        check("ack", 32'(bus.ack), 32'(exp_ack));
        if (!keep) bus.req = bus.req & ~exp_ack;
        @(negedge clk);
        check("ack_once", 32'(bus.ack), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         t_prev, t_now, n;
        logic [7:0] sb [7];
        logic [1:0] sg [7];
        int         nseq, rel;

        vecs[0] = '{4'b0001, 32'h000000A5, 8'hA5, 2'd0, 4'b0001};
        vecs[1] = '{4'b1100, 32'h5AC30000, 8'hC3, 2'd2, 4'b0100};
        vecs[2] = '{4'b0011, 32'h00007E81, 8'h81, 2'd0, 4'b0001};
        vecs[3] = '{4'b1010, 32'hF0003C00, 8'h3C, 2'd1, 4'b0010};
        vecs[4] = '{4'b1010, 32'hF0003C00, 8'hF0, 2'd3, 4'b1000};
        vecs[5] = '{4'b0010, 32'h00009900, 8'h99, 2'd1, 4'b0010};

        bus.req  = 4'b0000;
        bus.data = 32'h0;
        bus2.req = 4'b0000;
        bus2.data = 32'h0;
        @(negedge clk);
        bus.req  = 4'b0001;
        bus.data = 32'h000000A5;
        reset_and_flush();

        for (int i = 0; i < 6; i++) begin
            bus.req  = vecs[i].req;
            bus.data = vecs[i].data;
            run_frame(vecs[i].exp_byte, vecs[i].exp_gnt, vecs[i].exp_ack, 1'b0, 0, 4'b0000, t_now);
        end
        bus.req = 4'b0000;

        // All four requesting continuously after a fresh reset.
        reset_and_flush();
`ifdef UART_TX_ARB_PRIO_EN
        sb = '{8'h11, 8'h11, 8'h11, 8'h22, 8'h33, 8'h44, 8'h22};
        sg = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
        nseq = 7;
        rel = 3;
`else
        sb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h00, 8'h00};
        sg = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0};
        nseq = 5;
        rel = -1;
`endif
        bus.data = 32'h44332211;
        bus.req  = 4'b1111;
        t_prev = -1;
        for (int i = 0; i < nseq; i++) begin
            if (i == rel) bus.req = 4'b1110;
            run_frame(sb[i], sg[i], 4'b0001 << sg[i], 1'b1, 0, 4'b0000, t_now);
            if (t_prev >= 0) check("rr_spacing", 32'(t_now - t_prev), 32'd23);
            t_prev = t_now;
        end
        bus.req = 4'b0000;

        // req[2] drops in FRAME cycle 5 while 1 and 3 arrive; frame and ack still complete.
        bus.data = 32'hDDCCBB00;
        bus.req  = 4'b0100;
        run_frame(8'hCC, 2'd2, 4'b0100, 1'b0, 5, 4'b1010, t_now);
        run_frame(8'hDD, 2'd3, 4'b1000, 1'b0, 0, 4'b0000, t_now);
        run_frame(8'hBB, 2'd1, 4'b0010, 1'b0, 0, 4'b0000, t_now);
        check("drop_req_clear", 32'(bus.req), 32'd0);

        // Reset in FRAME cycle 10 discards the grant; the still-pending request is served after flush.
        bus.data = 32'h00C30000;
        bus.req  = 4'b0100;
        n = 0;
        while (bus.tx_ce !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midrst_start", 32'(bus.tx_data), 32'h000000C3);
        for (int i = 1; i <= 10; i++) @(negedge clk);
        reset_and_flush();
        run_frame(8'hC3, 2'd2, 4'b0100, 1'b0, 0, 4'b0000, t_now);

        // Zero-gap instance, two requesters held, bytes decoded by the serial model.
        bus2.data = 32'h00002211;
        bus2.req  = 4'b0011;
        n = 0;
        while (bus2.tx_ce !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        t_prev = cyc;
        check("gap0_first_byte", 32'(bus2.tx_data), 32'h00000011);
        @(negedge clk);
        n = 0;
        while (bus2.tx_ce !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("gap0_spacing", 32'(cyc - t_prev), 32'd21);
        for (int i = 0; i < 25; i++) @(negedge clk);
        bus2.req = 4'b0000;
        check("gap0_rx0", 32'(m_rx[0]), 32'({1'b1, 8'h11, 1'b0}));
`ifdef UART_TX_ARB_PRIO_EN
        check("gap0_rx1", 32'(m_rx[1]), 32'({1'b1, 8'h11, 1'b0}));
`else
        check("gap0_rx1", 32'(m_rx[1]), 32'({1'b1, 8'h22, 1'b0}));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 20, clocks per transmitter frame (start + 8 data + stop, two clocks per bit).
REQ-002 SHALL have parameter GAP_LEN, default 2, idle clocks between frames, range 0..15.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  4  per-requester transmit request, level, held until matching ack.
REQ-006 SHALL have port data  input  32  requester bytes, requester i on bits [8i+7:8i], stable while req[i]=1.
REQ-007 SHALL have port ack  output  4  one-cycle completion pulse to the granted requester.
REQ-008 SHALL have port tx_ce  output  1  active-low start strobe to the serial transmitter.
REQ-009 SHALL have port tx_data  output  8  byte driven to the transmitter's parallel input.
REQ-010 SHALL have port gnt_id  output  2  index of the requester owning the current frame.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL implement FSM states FLUSH, IDLE, START, FRAME, GAP.
REQ-013 SHALL in IDLE with req!=0 select a winner, latch its byte into tx_data and its index into gnt_id, and enter START on the next edge; with req=0 it SHALL remain in IDLE.
REQ-014 SHALL drive tx_ce=0 for exactly one cycle (START), with tx_ce=1 in all other states.
REQ-015 SHALL hold tx_data and gnt_id constant from START through the last FRAME cycle, because the transmitter samples its input on every bit.
REQ-016 SHALL stay in FRAME for FRAME_LEN-1 cycles, counted by a 5-bit down-counter loaded at START.
REQ-017 SHALL pulse ack[gnt_id]=1 for one cycle, on the first cycle after FRAME ends.
REQ-018 SHALL after FRAME spend GAP_LEN cycles in GAP and then return to IDLE; with GAP_LEN=0 it SHALL go from FRAME directly to IDLE.
REQ-019 SHALL arbitrate round-robin: the search starts at (last gnt_id+1) mod 4, and after reset the pointer is 0.
REQ-020 SHALL still complete the frame and pulse ack if the granted req drops mid-frame; no abort exists.
REQ-021 SHALL ignore req changes outside IDLE; requests are evaluated only in IDLE.
REQ-022 SHALL, when all four req are asserted, serve the requesters in the order 0,1,2,3,0,... with one frame each.
REQ-023 SHALL give back-to-back frames a tx_ce-to-tx_ce spacing of FRAME_LEN+GAP_LEN+1 cycles.

Reset
REQ-024 SHALL on rst set tx_ce=1, tx_data=0, ack=0, gnt_id=0, the round-robin pointer to 0, and the state to FLUSH.
REQ-025 SHALL stay in FLUSH for FRAME_LEN cycles with busy=1, so that a transmitter frame started before reset completes uncorrupted, and then enter IDLE.
REQ-026 SHALL let reset asserted mid-frame discard the current grant without generating an ack.

Configuration
REQ-027 SHALL support macro UART_TX_ARB_PRIO_EN.
REQ-028 SHALL, when UART_TX_ARB_PRIO_EN is defined, give requester 0 absolute priority: req[0]=1 in IDLE always wins, and requesters 1..3 are round-robin among themselves.
REQ-029 SHALL, when UART_TX_ARB_PRIO_EN is undefined, use pure 4-way round-robin per REQ-019.

Structure
REQ-030 SHALL take from the shared package uart_ctrl_pkg: the FSM state enum, NREQ=4, and the FRAME_LEN default constant.
REQ-031 SHALL place winner selection in sub-module rr_arbiter4 (inputs req, pointer, prio-enable; outputs valid, index), instantiated once.

Verification
REQ-032 SHALL cover: rst 1 cycle, then req=0001 with data[7:0]=8'hA5 on cycle 2 -> busy through FLUSH (20 cycles), then tx_ce low 1 cycle, tx_data=8'hA5 for 20 cycles, ack=0001 one cycle later.
REQ-033 SHALL cover: req=1111 held, data=32'h44332211 -> tx_data sequence 11,22,33,44,11; ack order 0001,0010,0100,1000; tx_ce pulses 23 cycles apart.
REQ-034 SHALL cover: with UART_TX_ARB_PRIO_EN, req=1111 held -> tx_data 11,11,11...; release req[0] -> 22,33,44,22.
REQ-035 SHALL cover: req[2] dropped in FRAME cycle 5 -> tx_data unchanged, ack=0100 still pulses once, next grant skips 2.
REQ-036 SHALL cover: rst asserted in FRAME cycle 10 -> tx_ce=1 and no ack; busy high for 20 cycles; then the pending req is served normally.
REQ-037 SHALL cover: GAP_LEN=0, req=0011 held -> tx_ce pulses exactly 21 cycles apart, with an external transmitter model decoding bytes 11,22 correctly.
